// File: rtl/mc_controlpath_if.sv
// mc_controlpath_if: control unit <-> datapath/memory signal bundle
interface mc_controlpath_if #(
  parameter int OPFN_W  = 5,
  parameter int ALUFN_W = 3,
  parameter int CNT_W   = 16
);
  logic [OPFN_W-1:0]  OpFn;
  logic               alu_zero;
  logic               mem_ready;
  logic               PCWrite;
  logic               IRWrite;
  logic               NIA;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrc;
  logic               MemRead;
  logic               MemWrite;
  logic               MemToReg;
  logic [ALUFN_W-1:0] ALUFn;
  logic [2:0]         state;
  logic               err;
  logic [CNT_W-1:0]   retired;
  logic [CNT_W-1:0]   stalls;
  modport master (
    input  OpFn, alu_zero, mem_ready,
    output PCWrite, IRWrite, NIA, RegDst, RegWrite, ALUSrc, MemRead, MemWrite,
           MemToReg, ALUFn, state, err, retired, stalls
  );
  modport slave (
    output OpFn, alu_zero, mem_ready,
    input  PCWrite, IRWrite, NIA, RegDst, RegWrite, ALUSrc, MemRead, MemWrite,
           MemToReg, ALUFn, state, err, retired, stalls
  );
endinterface

// File: rtl/mc_controlpath.sv
// mc_controlpath: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit; define MC_CTRL_PERFCNT_EN for retired/stalls counters
module mc_controlpath #(
  parameter int OPFN_W  = 5,
  parameter int ALUFN_W = 3,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  mc_controlpath_if.master  bus
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd7;
  logic [2:0]         state_q, state_d;
  logic [OPFN_W-1:0]  op_q, op_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic [1:0]         cls_q, cls_in;
  logic [ALUFN_W-1:0] f_q, f_in;
  logic               illegal, is_load, is_store, is_beq, is_jump, in_mem, stall, pcw;
  assign cls_in   = bus.OpFn[OPFN_W-1 -: 2];
  assign f_in     = bus.OpFn[ALUFN_W-1:0];
  assign cls_q    = op_q[OPFN_W-1 -: 2];
  assign f_q      = op_q[ALUFN_W-1:0];
  assign illegal  = cls_in == 2'b11 && f_in > ALUFN_W'(1);
  assign is_load  = cls_q == 2'b10 && !f_q[0];
  assign is_store = cls_q == 2'b10 && f_q[0];
  assign is_beq   = cls_q == 2'b11 && f_q == ALUFN_W'(0);
  assign is_jump  = cls_q == 2'b11 && f_q == ALUFN_W'(1);
  assign in_mem   = state_q == S_MEM;
  assign stall    = in_mem && !bus.mem_ready;
  // next-state, opcode latch and MEM wait counter
  always_comb begin
    op_d    = state_q == S_DECODE ? bus.OpFn : op_q;
    wcnt_d  = stall ? wcnt_q + 8'd1 : 8'd0;
    state_d = state_q == S_FETCH  ? S_DECODE :
              state_q == S_DECODE ? (illegal ? S_ERR : S_EXEC) :
              state_q == S_EXEC   ? (cls_q[1] ? (cls_q[0] ? S_FETCH : S_MEM) : S_WB) :
              state_q == S_MEM    ? (bus.mem_ready ? (is_load ? S_WB : S_FETCH) :
                                     (wcnt_q == 8'(TIMEOUT - 1) ? S_ERR : S_MEM)) :
              state_q == S_WB     ? S_FETCH : S_ERR;
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wcnt_q  <= wcnt_d;
    end
  end
  assign pcw          = (state_q == S_EXEC && cls_q == 2'b11) || (in_mem && bus.mem_ready && is_store) ||
                        state_q == S_WB;
  assign bus.PCWrite  = pcw;
  assign bus.IRWrite  = state_q == S_FETCH;
  assign bus.NIA      = state_q == S_EXEC && (is_jump || (is_beq && bus.alu_zero));
  assign bus.RegDst   = state_q == S_WB && cls_q == 2'b00;
  assign bus.RegWrite = state_q == S_WB;
  assign bus.ALUSrc   = state_q == S_EXEC && (cls_q == 2'b01 || cls_q == 2'b10);
  assign bus.MemRead  = in_mem && is_load;
  assign bus.MemWrite = in_mem && is_store;
  assign bus.MemToReg = state_q == S_WB && is_load;
  assign bus.ALUFn    = state_q != S_EXEC ? '0 : cls_q[1] ? ALUFN_W'(is_beq) : f_q;
  assign bus.state    = state_q;
  assign bus.err      = state_q == S_ERR;
`ifdef MC_CTRL_PERFCNT_EN
  logic [CNT_W-1:0] retired_q, retired_d, stalls_q, stalls_d;
  // performance counters, wrapping naturally
  always_comb begin
    retired_d = retired_q + CNT_W'(pcw);
    stalls_d  = stalls_q + CNT_W'(stall);
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      retired_q <= '0;
      stalls_q  <= '0;
    end else begin
      retired_q <= retired_d;
      stalls_q  <= stalls_d;
    end
  end
  assign bus.retired = retired_q;
  assign bus.stalls  = stalls_q;
`else
  assign bus.retired = '0;
  assign bus.stalls  = '0;
`endif
endmodule

// File: tb/tb_mc_controlpath.sv
// tb_mc_controlpath: randomized self-checking bench against a latency/decode-table model
module tb_mc_controlpath;
  localparam int TIMEOUT = 15;
`ifdef MC_CTRL_PERFCNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   ret_m = 0;
  int   stl_m = 0;
  mc_controlpath_if #(.OPFN_W(5), .ALUFN_W(3), .CNT_W(16)) bus ();
  mc_controlpath #(.OPFN_W(5), .ALUFN_W(3), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  // {PCWrite,IRWrite,NIA,RegDst,RegWrite,ALUSrc,MemRead,MemWrite,MemToReg,err,ALUFn}
  function automatic logic [12:0] exp_vec(input int s, input logic [4:0] op, input logic z, input logic r);
    logic [1:0] c = op[4:3];
    logic [2:0] f = op[2:0];
    logic pcw = 0, irw = 0, nia = 0, rd = 0, rw = 0, as = 0, mr = 0, mw = 0, m2r = 0, er = 0;
    logic [2:0] fn = 0;
    if (s == 0) irw = 1;
    if (s == 2) begin
      if (c == 2'b00 || c == 2'b01) fn = f;
      if (c == 2'b01 || c == 2'b10) as = 1;
      if (c == 2'b11) begin
        pcw = 1;
        nia = (f == 1) || (f == 0 && z);
        fn  = (f == 0) ? 3'd1 : 3'd0;
      end
    end
    if (s == 3) begin
      mr  = !f[0];
      mw  = f[0];
      pcw = f[0] && r;
    end
    if (s == 4) begin
      rw = 1; pcw = 1;
      m2r = (c == 2'b10);
      rd  = (c == 2'b00);
    end
    if (s == 7) er = 1;
    return {pcw, irw, nia, rd, rw, as, mr, mw, m2r, er, fn};
  endfunction
  function automatic logic [15:0] exp_cnt(input int v);
    return PERF ? 16'(v) : 16'd0;
  endfunction
  // Runs one instruction starting in a FETCH cycle; w = mem_ready=0 cycles requested in MEM
  task automatic run_instr(input string name, input logic [4:0] op, input logic z, input int w);
    int q[$];
    logic [1:0] c = op[4:3];
    logic [2:0] f = op[2:0];
    int k = 0, lat = -1, exp_lat = -1;
    logic r;
    logic [12:0] got, ev;
    q = {0, 1};
    if (c == 2'b11 && f > 1) q = {0, 1, 7, 7, 7};
    else begin
      q.push_back(2);
      if (!c[1]) begin q.push_back(4); exp_lat = 4; end
      else if (c == 2'b11) exp_lat = 3;
      else begin
        for (int i = 0; i < ((w >= TIMEOUT) ? TIMEOUT : w + 1); i++) q.push_back(3);
        if (w >= TIMEOUT) begin q.push_back(7); q.push_back(7); end
        else if (!f[0]) begin q.push_back(4); exp_lat = 5 + w; end
        else exp_lat = 4 + w;
        stl_m += (w >= TIMEOUT) ? TIMEOUT : w;
      end
    end
    if (exp_lat > 0) ret_m++;
    for (int i = 0; i < q.size(); i++) begin
      bus.OpFn      = (q[i] == 1) ? op : 5'($urandom);
      bus.alu_zero  = (q[i] == 2) ? z : 1'($urandom);
      r             = (q[i] == 3) ? (k >= w) : 1'($urandom);
      bus.mem_ready = r;
      if (q[i] == 3) k++;
      #1;
      got = {bus.PCWrite, bus.IRWrite, bus.NIA, bus.RegDst, bus.RegWrite, bus.ALUSrc,
             bus.MemRead, bus.MemWrite, bus.MemToReg, bus.err, bus.ALUFn};
      if (q[i] == 2 && c == 2'b11 && f == 1) got[2:0] = 3'd0;
      ev = exp_vec(q[i], op, z, r);
      n_chk++;
      if (bus.state !== 3'(q[i])) begin
        n_fail++;
        $display("FAIL %s cyc%0d state got %0d exp %0d", name, i, bus.state, q[i]);
      end
      n_chk++;
      if (got !== ev) begin
        n_fail++;
        $display("FAIL %s cyc%0d strobes got %b exp %b", name, i, got, ev);
      end
      if (bus.PCWrite === 1'b1 && lat < 0) lat = i + 1;
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat);
    end
    n_chk++;
    if (bus.retired !== exp_cnt(ret_m) || bus.stalls !== exp_cnt(stl_m)) begin
      n_fail++;
      $display("FAIL %s counters got %0d/%0d exp %0d/%0d", name, bus.retired, bus.stalls,
               exp_cnt(ret_m), exp_cnt(stl_m));
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    bus.alu_zero = 1'b0;
    bus.OpFn = 5'd0;
    @(posedge clk);
    #1;
    n_chk++;
    if (bus.state !== 3'd0 || bus.IRWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold state got %0d irw %b exp 0 1", bus.state, bus.IRWrite);
    end
    @(posedge clk);
    #1;
    ret_m = 0;
    stl_m = 0;
    rst = 1'b1;
    n_chk++;
    if (bus.state !== 3'd0 || bus.IRWrite !== 1'b1 || bus.err !== 1'b0 || bus.retired !== 16'd0 ||
        bus.stalls !== 16'd0 || bus.PCWrite !== 1'b0 || bus.RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset state %0d irw %b err %b ret %0d stl %0d exp 0 1 0 0 0", bus.state,
               bus.IRWrite, bus.err, bus.retired, bus.stalls);
    end
  endtask
  task automatic test_rtype();
    run_instr("rtype", 5'b00010, 1'b0, 0);
    run_instr("itype", 5'b01101, 1'b1, 0);
  endtask
  task automatic test_branch();
    run_instr("beq_taken", 5'b11000, 1'b1, 0);
    run_instr("beq_not", 5'b11000, 1'b0, 0);
    run_instr("jump", 5'b11001, 1'b0, 0);
  endtask
  task automatic test_load_store();
    run_instr("load_w3", 5'b10000, 1'b0, 3);
    run_instr("store_w0", 5'b10001, 1'b0, 0);
    run_instr("load_w0", 5'b10110, 1'b0, 0);
    run_instr("load_w14", 5'b10000, 1'b0, TIMEOUT - 1);
  endtask
  task automatic test_timeout();
    run_instr("store_timeout", 5'b10001, 1'b0, 1000);
    test_reset();
  endtask
  task automatic test_illegal();
    run_instr("illegal", 5'b11011, 1'b0, 0);
    test_reset();
  endtask
  task automatic test_reset_mid_mem();
    logic [4:0] seq_op [4] = '{5'd31, 5'b10000, 5'd31, 5'd31};
    for (int i = 0; i < 5; i++) begin
      bus.OpFn = seq_op[i % 4];
      bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (bus.state !== 3'd3 || bus.MemRead !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mem_pre state got %0d rd %b exp 3 1", bus.state, bus.MemRead);
    end
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ret_m = 0;
    stl_m = 0;
    n_chk++;
    if (bus.state !== 3'd0 || bus.RegWrite !== 1'b0 || bus.IRWrite !== 1'b1 ||
        bus.stalls !== 16'd0 || bus.retired !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_mem_reset state got %0d rw %b irw %b stl %0d exp 0 0 1 0", bus.state,
               bus.RegWrite, bus.IRWrite, bus.stalls);
    end
  endtask
  task automatic test_random();
    logic [4:0] op;
    for (int n = 0; n < 60; n++) begin
      op[4:3] = 2'($urandom);
      op[2:0] = (op[4:3] == 2'b11) ? 3'($urandom_range(0, 1)) : 3'($urandom);
      run_instr("random", op, 1'($urandom), int'($urandom_range(0, 5)));
    end
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_load_store();
    test_timeout();
    test_illegal();
    test_reset_mid_mem();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_controlpath.md
# mc_controlpath

Parametrised multi-cycle control unit for the 16-bit processor: the next-generation successor to the single-cycle `controlpath`. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. It drives the same datapath strobes plus PC/IR write enables. It also stalls on a data-memory ready handshake and flags illegal opcodes and memory timeouts.

## Interface
Parameters:
- OPFN_W, 5: opcode/function field width; must be >= ALUFN_W+2.
- ALUFN_W, 3: ALU function select width.
- TIMEOUT, 15: maximum MEM-state wait cycles before timeout error; range 1..255.
- CNT_W, 16: performance counter width.

Ports:
- clk: in, 1, rising-edge clock.
- rst: in, 1, synchronous, active-low reset.
- OpFn: in, OPFN_W, opcode from the datapath IR.
- alu_zero: in, 1, ALU equality flag for branches.
- mem_ready: in, 1, data-memory access complete.
- PCWrite: out, 1, PC update enable.
- IRWrite: out, 1, instruction register load.
- NIA: out, 1, next-address select; 1 selects the branch/jump target.
- RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg: out, 1 each, datapath strobes.
- ALUFn: out, ALUFN_W, ALU function.
- state: out, 3, current state encoding.
- err: out, 1, sticky error flag.
- retired: out, CNT_W, retired-instruction count.
- stalls: out, CNT_W, MEM wait-cycle count.

## Operation
- Opcode class is OpFn[OPFN_W-1:OPFN_W-2]; f = OpFn[ALUFN_W-1:0].
  - 00: R-type; ALUFn=f, RegDst=1.
  - 01: I-type; ALUFn=f, ALUSrc=1.
  - 10: memory; f[0]=0 is load, f[0]=1 is store. ALUFn=0 (add), ALUSrc=1.
  - 11: branch; f=0 is beq (ALUFn=1, subtract), f=1 is jump. Any other f is illegal.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7.
- FETCH: IRWrite=1, then go to DECODE.
- DECODE: OpFn is latched into op_q at the end of the cycle. An illegal opcode goes to ERR; otherwise go to EXEC.
- EXEC:
  - ALUFn and ALUSrc are driven from op_q.
  - R/I-type goes to WB.
  - Memory goes to MEM.
  - Branch goes to FETCH with PCWrite=1. NIA=1 if jump, or if beq and alu_zero=1; otherwise NIA=0.
- MEM:
  - MemRead (load) or MemWrite (store) is held until mem_ready=1.
  - On mem_ready, a load goes to WB. A store goes to FETCH with PCWrite=1, NIA=0.
  - The wait counter counts cycles with mem_ready=0. When it reaches TIMEOUT, go to ERR.
- WB: RegWrite=1, plus MemToReg=1 for loads and RegDst=1 for R-type. PCWrite=1, NIA=0. Then go to FETCH.
- ERR: all strobes are 0 and err=1. Exit only by reset.
- Outputs are a Moore decode of the state and op_q. Any strobe not listed for a state is 0.
- retired increments on every cycle with PCWrite=1. stalls increments on every MEM cycle with mem_ready=0. Both wrap modulo 2^CNT_W.

## Timing
- Reset (rst=0 at a clk edge):
  - state=FETCH and op_q=0.
  - Wait counter, retired and stalls are cleared to 0; err=0.
  - Outputs during reset follow FETCH decode: IRWrite=1, all other strobes 0.
- Reset wins over every other event, including mid-MEM and while in ERR.
- Latency, FETCH to the PCWrite cycle inclusive:
  - R/I-type: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4+w cycles.
  - Load: 5+w cycles.
  - w is the number of mem_ready=0 cycles in MEM.
- mem_ready=1 in the first MEM cycle means zero wait; the access completes in that cycle.
- mem_ready is ignored outside MEM.
- Timeout: TIMEOUT consecutive mem_ready=0 cycles means the next state is ERR. mem_ready=1 on that same cycle completes normally instead; ready has priority.
- A strobe's request is held stable for the whole MEM stall.
- OpFn changes outside DECODE have no effect.

## Configuration
- MC_CTRL_PERFCNT_EN defined: the retired and stalls counters are implemented as described.
- Not defined: no counter flops; retired and stalls are tied to 0. All other behaviour is identical.

## Test plan
- Reset with rst=0 for 2 cycles, then release → state=0, IRWrite=1, err=0, retired=0.
- R-type OpFn=5'b00010 → state sequence 0,1,2,4; ALUFn=3'b010 in EXEC; RegWrite=1, RegDst=1 and PCWrite=1 in WB; retired=1.
- beq OpFn=5'b11000 with alu_zero=1 → state sequence 0,1,2,0; ALUFn=1 and PCWrite=1, NIA=1 in EXEC. Repeat with alu_zero=0 → NIA=0.
- Load OpFn=5'b10000 with mem_ready low for 3 MEM cycles → MemRead held 4 cycles; WB shows MemToReg=1, RegWrite=1; stalls=3; total latency 8 cycles.
- Store with mem_ready never asserted and TIMEOUT=15 → 15 MEM cycles, then state=7, err=1, all strobes 0. rst=0 recovers to FETCH.
- Illegal OpFn=5'b11011 → ERR after DECODE; err=1. Asserting rst=0 mid-MEM on a later load returns state=0 on the next edge with no RegWrite.
